fp32_to_int32_converter: RTL and testbench

- Converts an IEEE-754 binary32 value to a signed 32-bit integer. Rounding is toward zero, matching C cast semantics, and out-of-range inputs saturate.
- This is the reverse direction of the int-to-float normalisation path. That path counts leading zeros and shifts left; this block right-shifts the significand by a computed amount in five log stages (16/8/4/2/1), one stage per cycle.
- It sits in the fp32_adder datapath as the conversion unit. Valid/ready handshakes on both sides.

---
 rtl/fp32_to_int32_converter_if.sv | 15 +
 rtl/fp32_to_int32_converter.sv | 92 +++++++++
 tb/tb_fp32_to_int32_converter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fp32_to_int32_converter_if.sv
// fp32_to_int32_converter_if: valid/ready operand and result channels of the fp32 to int32 converter.
interface fp32_to_int32_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_invalid, out_inexact);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_invalid, out_inexact);
endinterface

// File: rtl/fp32_to_int32_converter.sv
// fp32_to_int32_converter: truncating fp32 to int32 conversion with saturation, using a five-stage log right shifter.
module fp32_to_int32_converter #(
  parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
  input logic clk,
  input logic rst,
  fp32_to_int32_converter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, NEG, DONE} state_t;
  state_t      state;
  logic [31:0] din, w, w_shift, f_data, force_data;
  logic [7:0]  e, sh_full;
  logic [22:0] m;
  logic [4:0]  sh, amt;
  logic [2:0]  k, bit_idx;
  logic        s, zero, tiny, nan, min_neg, in_range, lost;
  logic        sticky, norm, force_inv, force_inx;
  always_comb begin
    s        = din[31];
    e        = din[30:23];
    m        = din[22:0];
    zero     = e == 8'd0 && m == 23'd0;
    tiny     = !zero && e < 8'd127;
    nan      = e == 8'hFF && m != 23'd0;
    in_range = e >= 8'd127 && e <= 8'd157;
    min_neg  = e == 8'd158 && s && m == 23'd0;
    sh_full  = 8'd158 - e;
    bit_idx  = 3'd4 - k;
    amt      = sh[bit_idx] ? 5'd1 << bit_idx : 5'd0;
    w_shift  = w >> amt;
    lost     = |(w & ((32'd1 << amt) - 32'd1));
    f_data   = nan ? NAN_RESULT : (zero || tiny) ? 32'd0 : s ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= 32'd0;
      bus.out_invalid <= 1'b0;
      bus.out_inexact <= 1'b0;
      din             <= 32'd0;
      w               <= 32'd0;
      sh              <= 5'd0;
      k               <= 3'd0;
      sticky          <= 1'b0;
      norm            <= 1'b0;
      force_data      <= 32'd0;
      force_inv       <= 1'b0;
      force_inx       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          din          <= bus.in_data;
          bus.in_ready <= 1'b0;
          state        <= UNPACK;
        end
        UNPACK: begin
          w          <= {1'b1, m, 8'b0};
          sticky     <= 1'b0;
          sh         <= sh_full[4:0];
          norm       <= in_range;
          force_data <= f_data;
          force_inv  <= !(zero || tiny || min_neg);
          force_inx  <= tiny;
          k          <= 3'd0;
          state      <= SHIFT;
        end
        // Runs all five stages regardless of class so latency is fixed.
        SHIFT: begin
          w      <= w_shift;
          sticky <= sticky | lost;
          k      <= k + 3'd1;
          if (k == 3'd4) state <= NEG;
        end
        NEG: begin
          bus.out_data    <= norm ? (s ? -w : w) : force_data;
          bus.out_invalid <= norm ? 1'b0 : force_inv;
          bus.out_inexact <= norm ? sticky : force_inx;
          bus.out_valid   <= 1'b1;
          state           <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_to_int32_converter.sv
// tb_fp32_to_int32_converter: randomized and directed checks of the converter against a truncating-conversion model.
module tb_fp32_to_int32_converter;
  localparam logic [31:0] NAN_RESULT = 32'h7FFF_FFFF;
  typedef struct {logic [31:0] d; logic inv; logic inx; int acc;} exp_t;
  typedef struct {logic [31:0] x; logic [31:0] d; logic inv; logic inx;} pin_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_ready = 1'b0;
  logic exp_ov;
  int   cyc = 0, checks = 0, errors = 0, last_acc = -100;
  exp_t q[$];
  fp32_to_int32_converter_if bus();
  fp32_to_int32_converter #(.NAN_RESULT(NAN_RESULT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Value-level truncation: scale the significand by 2^E, chop the fraction, then range-check.
  function automatic void model(input logic [31:0] x, output logic [31:0] d, output logic inv, output logic inx);
    logic [7:0]  e = x[30:23];
    logic [22:0] m = x[22:0];
    logic        s = x[31];
    logic [31:0] sat = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    longint      mag, v;
    int          ex;
    d = 32'd0; inv = 1'b0; inx = 1'b0;
    if (e == 8'hFF) begin
      inv = 1'b1;
      d = (m != 23'd0) ? NAN_RESULT : sat;
    end else if (e == 8'd0) begin
      inx = m != 23'd0;
    end else begin
      ex = int'(e) - 127;
      mag = longint'({1'b1, m});
      if (ex < 0) inx = 1'b1;
      else if (ex >= 32) begin inv = 1'b1; d = sat; end
      else begin
        if (ex >= 23) mag = mag << (ex - 23);
        else begin
          inx = (mag % (64'sd1 << (23 - ex))) != 0;
          mag = mag >> (23 - ex);
        end
        v = s ? -mag : mag;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) begin inv = 1'b1; inx = 1'b0; d = sat; end
        else d = v[31:0];
      end
    end
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_acc = -100;
    end else begin
      checks++;
      if (bus.in_ready !== (q.size() == 0)) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got %b exp %b", cyc, bus.in_ready, q.size() == 0);
      end
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = cyc >= q[0].acc + 7;
      checks++;
      if (bus.out_valid !== exp_ov) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got %b exp %b", cyc, bus.out_valid, exp_ov);
      end
      if (bus.out_valid && exp_ov) begin
        checks++;
        if ({bus.out_data, bus.out_invalid, bus.out_inexact} !== {q[0].d, q[0].inv, q[0].inx}) begin
          errors++;
          $display("FAIL result cyc=%0d got %h inv=%b inx=%b exp %h inv=%b inx=%b",
                   cyc, bus.out_data, bus.out_invalid, bus.out_inexact, q[0].d, q[0].inv, q[0].inx);
        end
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t t;
        model(bus.in_data, t.d, t.inv, t.inx);
        t.acc = cyc + 1;
        q.push_back(t);
        checks++;
        if (t.acc - last_acc < 8) begin
          errors++;
          $display("FAIL accept_spacing cyc=%0d got %0d exp >=8", cyc, t.acc - last_acc);
        end
        last_acc = t.acc;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic send(input logic [31:0] x);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_data = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      if (ok) return;
    end
    errors++;
    $display("FAIL send_timeout got no accept exp accept for %h", x);
  endtask
  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && !bus.out_valid) return;
      tick();
    end
    errors++;
    $display("FAIL drain_timeout got pending=%0d exp 0", q.size());
  endtask
  pin_t pins[12] = '{
    '{32'h42F6E979, 32'h0000007B, 1'b0, 1'b1},
    '{32'hCF000000, 32'h80000000, 1'b0, 1'b0},
    '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},
    '{32'h7FC00000, NAN_RESULT,   1'b1, 1'b0},
    '{32'hFF800000, 32'h80000000, 1'b1, 1'b0},
    '{32'h80000000, 32'h00000000, 1'b0, 1'b0},
    '{32'h00000001, 32'h00000000, 1'b0, 1'b1},
    '{32'h3F000000, 32'h00000000, 1'b0, 1'b1},
    '{32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h41200000, 32'h0000000A, 1'b0, 1'b0},
    '{32'hC1200000, 32'hFFFFFFF6, 1'b0, 1'b0}};
  initial begin
    logic [31:0] d, x;
    logic        inv, inx;
    logic [7:0]  e;
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_data, bus.out_invalid, bus.out_inexact, bus.out_valid, bus.in_ready} !== {32'd0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_outputs got %h %b%b%b%b exp 00000000 0001",
               bus.out_data, bus.out_invalid, bus.out_inexact, bus.out_valid, bus.in_ready);
    end
    foreach (pins[i]) begin
      model(pins[i].x, d, inv, inx);
      checks++;
      if ({d, inv, inx} !== {pins[i].d, pins[i].inv, pins[i].inx}) begin
        errors++;
        $display("FAIL model_pin %h got %h %b%b exp %h %b%b", pins[i].x, d, inv, inx, pins[i].d, pins[i].inv, pins[i].inx);
      end
    end
    for (int i = 0; i < 10; i++) begin
      send(pins[i].x);
      bus.in_valid = 1'b0;
      drain();
    end
    bus.out_ready = 1'b0;
    send(32'h41200000);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_data = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    send(32'h40490FDB);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
    repeat (20) tick();
    send(32'hC1200000);
    bus.in_valid = 1'b0;
    drain();
    send(32'h42F6E979);
    send(32'hC2C80000);
    send(32'h3FC00000);
    bus.in_valid = 1'b0;
    drain();
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: e = 8'd0;
        1: e = 8'hFF;
        2: e = 8'($urandom_range(120, 135));
        3: e = 8'($urandom_range(150, 160));
        default: e = 8'($urandom_range(0, 255));
      endcase
      x = $urandom;
      x[30:23] = e;
      if ($urandom_range(0, 3) == 0) x[22:0] = 23'd0;
      send(x);
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
